// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default framing constants
// and the line idle level used by both the RX and TX stages.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    localparam logic IDLE_LEVEL = 1'b1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer for asynchronous pin inputs; the reset value is chosen
// per pin so the synchronized level matches the line's idle state.
module sync_ff2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Metastability filter: two back-to-back flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver with 16x oversampling, 3-sample majority vote per bit
// and a single-entry holding register carrying ready/frame-error/overrun status.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] data,
    output logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE) + 1;
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] T_LO     = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_MID    = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_HI     = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_END    = TW'(OVERSAMPLE);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    rx_state_t            state;
    logic                 rx_s;
    logic [TW-1:0]        tick_cnt;
    logic [TW-1:0]        tick_next;
    logic [BW-1:0]        bit_idx;
    logic [2:0]           votes;
    logic [DATA_BITS-1:0] shreg;

    logic in_bit;
    logic bit_end;
    logic stop_point;
    logic bit_vote;
    logic stop_vote;

    sync_ff2 #(
        .RESET_VAL(IDLE_LEVEL)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

    // Bit timing decode; the stop vote folds in the live sample taken on its last tick.
    always_comb begin
        tick_next  = tick_cnt + TW'(1);
        in_bit     = (state == START) || (state == DATA) || (state == STOP);
        bit_end    = in_bit && tick && (tick_next == T_END);
        stop_point = (state == STOP) && tick && (tick_next == T_HI);
        bit_vote   = majority3(votes[0], votes[1], votes[2]);
        stop_vote  = majority3(votes[0], votes[1], rx_s);
    end

    // Frame sequencer: tick counting, vote capture, shifting and state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= {TW{1'b0}};
            bit_idx  <= {BW{1'b0}};
            votes    <= 3'b000;
            shreg    <= {DATA_BITS{1'b0}};
        end else begin
            if (in_bit && tick) begin
                tick_cnt <= tick_next;
                if (tick_next == T_LO) begin
                    votes[0] <= rx_s;
                end
                if (tick_next == T_MID) begin
                    votes[1] <= rx_s;
                end
                if (tick_next == T_HI) begin
                    votes[2] <= rx_s;
                end
            end
            case (state)
                IDLE: begin
                    if (rx_s != IDLE_LEVEL) begin
                        state    <= START;
                        tick_cnt <= {TW{1'b0}};
                        votes    <= 3'b000;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tick_cnt <= {TW{1'b0}};
                        if (bit_vote) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_idx <= {BW{1'b0}};
                        end
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        tick_cnt <= {TW{1'b0}};
                        shreg    <= {bit_vote, shreg[DATA_BITS-1:1]};
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end
                end
                STOP: begin
                    // Decide mid stop bit so a back-to-back start edge is not missed.
                    if (stop_point) begin
                        tick_cnt <= {TW{1'b0}};
                        state    <= stop_vote ? IDLE : WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s == IDLE_LEVEL) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Host holding register: completion load, overrun detection and read acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data      <= {DATA_BITS{1'b0}};
            ready     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (stop_point) begin
            if (!ready || rd) begin
                data      <= shreg;
                ready     <= 1'b1;
                frame_err <= ~stop_vote;
                if (rd) begin
                    overrun <= 1'b0;
                end
            end else begin
                overrun <= 1'b1;
            end
        end else if (rd) begin
            ready     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the 8N1 stream driven onto the board's serial line by the transmitter stage. It is the receive-side counterpart of the TX path. It samples the line with a 16x oversampling tick from the shared baud generator, de-frames one byte at a time, and holds it in a single-entry holding register for the host bus. The register carries ready, frame-error and overrun status.

## Interface
Parameters:
- OVERSAMPLE, 16, ticks per bit period; must be even and ≥ 8
- DATA_BITS, 8, data bits per frame, LSB first

Ports:
- clk  in  1  system clock; everything is synchronous to it
- rst  in  1  reset, asynchronous and active-high; one clock
- tick  in  1  oversampling strobe, one clk cycle wide, OVERSAMPLE per bit
- rx  in  1  serial input, idle high, asynchronous to clk
- rd  in  1  one-cycle read strobe from host; acknowledges held byte
- data  out  DATA_BITS  held byte; valid while ready=1
- ready  out  1  holding register contains an unread byte
- frame_err  out  1  held byte's stop bit sampled low
- overrun  out  1  sticky: a completed byte was dropped while ready=1
- busy  out  1  receiver is inside a frame (state ≠ IDLE)

## Operation
- Input path: rx passes through a 2-flop synchronizer (both flops reset to 1); rx_s denotes the synchronized level.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: when rx_s=0, go to START, clear tick_cnt, and clear the vote bits. Detection is independent of tick.
- tick_cnt counts ticks within the current bit. It increments on each tick, numbered 1..OVERSAMPLE.
- Vote: rx_s is captured on ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 (7, 8, 9). The bit value is the majority of the 3 captures.
- START: at tick OVERSAMPLE, if the vote is 1 (false start), go to IDLE. Otherwise go to DATA with bit_idx=0.
- DATA: at tick OVERSAMPLE, shift the voted bit into shreg MSB-first shifting, so the first received bit ends at shreg[0].
  - If bit_idx=DATA_BITS-1, go to STOP.
  - Else increment bit_idx.
- STOP: the decision is made at tick OVERSAMPLE/2+1, not at bit end. This lets the receiver resync to back-to-back frames.
  - Complete the byte; see "completion" below.
  - Vote 1: go to IDLE.
  - Vote 0: go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. This absorbs break conditions without false starts.
- Completion when ready=0, or when ready=1 and rd is asserted the same cycle:
  - load data=shreg;
  - ready←1;
  - frame_err←(stop vote==0).
- Completion when ready=1 and rd=0: the new byte is discarded; overrun←1; data, frame_err and ready are unchanged.
- rd while ready=1 and no completion: ready←0 and frame_err←0; overrun←0; data is retained.
- rd while ready=0: overrun←0; otherwise no effect.
- Tick counting and bit counting never wrap inside a bit. tick_cnt is cleared at every bit transition.
- Widths: tick_cnt is $clog2(OVERSAMPLE)+1 bits; bit_idx is $clog2(DATA_BITS) bits.

## Timing
- Reset (asynchronous assert; deassert sampled on clk) takes effect immediately, including mid-frame:
  - outputs: data=0, ready=0, frame_err=0, overrun=0, busy=0;
  - FSM=IDLE;
  - synchronizer=1.
- Falling edge on rx to busy=1: 3 clk cycles (2 synchronizer flops plus the state register).
- ready rises 1 clk after the stop-bit tick 9, i.e. the registered output of the completion cycle.
- A frame's data is available ≈ (1 + DATA_BITS + 0.5) bit periods plus 3 clk cycles after the start edge.
- The status outputs (ready, frame_err, overrun) and data are all registered; nothing goes combinationally from rd to an output.
- tick and rd may coincide with any state; rd never affects the FSM.

## Structure
- Package uart_pkg holds:
  - the rx_state_t enum (IDLE, START, DATA, STOP, WAIT_IDLE);
  - default OVERSAMPLE and DATA_BITS constants;
  - IDLE_LEVEL=1'b1, shared with the TX stage.
- Sub-module sync_ff2 is a 2-flop synchronizer with a reset value parameter. The same codebase reuses it for other pin inputs.
- Everything else stays in uart_rx.

## Test plan
All scenarios use tick every 4 clk, OVERSAMPLE=16, DATA_BITS=8.
- Clean frame: send 0xA5 8N1 → data=0xA5, ready=1, frame_err=0, overrun=0; busy falls within 1 clk of the stop vote.
- Glitch: rx low for 5 ticks, then high → state returns to IDLE at the end of the START bit; ready stays 0.
- Single-tick spike: a spike on tick 8 of data bit 3 while sending 0x00 → majority rejects it; data=0x00.
- Framing error: send 0x3C with stop bit 0 held for 3 bit times → data=0x3C, frame_err=1; no new start is detected until rx returns high.
- Overrun and read behaviour:
  - send 0x11 then 0x22 back-to-back without rd → data=0x11, overrun=1;
  - rd → ready=0, overrun=0;
  - rd asserted in the same cycle as a completion → new byte loaded, ready stays 1, overrun=0.
- Reset mid-frame: assert rst during data bit 4 → all outputs 0 in the same cycle; after release, a following 0x5A frame is received correctly.
